// File: rtl/turf_bus_pkg.sv
// Shared types and constants for the TURF register-bus arbiter.
//
// Contents:
//   TURF_ADDR_W / TURF_BANK_W / TURF_DATA_W : downstream field widths
//   TURF_ERR_DATA                           : read data returned on a timeout
//   state_e                                 : arbiter sequencing states
package turf_bus_pkg;

    localparam int TURF_ADDR_W = 6;
    localparam int TURF_BANK_W = 2;
    localparam int TURF_DATA_W = 32;

    localparam logic [TURF_DATA_W-1:0] TURF_ERR_DATA = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_e;

endpackage

// File: rtl/turf_rr_arb2.sv
// Two-input round-robin arbiter.
//
// Ports:
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset; pointer resets so master 0
//                wins the first tie
//   req_i      : request vector, bit n = master n
//   grant_en_i : the grant is being taken this cycle; advance the pointer
//   gnt_o      : one-hot grant (zero when nothing requests)
module turf_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // On a tie the master that did not win last time is picked; a sole
    // requester is granted directly.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (grant_en_i && (req_i != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/turf_bus_arbiter.sv
// Two-master arbiter and sequencer in front of the TURF register-interface
// master. Master 0 is the host control path, master 1 the status poller.
// One transaction at a time is issued downstream, with a no-ack timeout and
// a forced idle gap between transactions.
//
// Ports:
//   clk_i, rst_i       : clock and synchronous active-high reset
//   m_wr_i / m_rd_i    : per-master write/read requests, held until ack
//   m_addr_i/m_bank_i/m_dat_i : packed per-master address, bank, write data
//   m_dat_o            : shared read data, valid in the ack cycle, then held
//   m_ack_o / m_err_o  : one-cycle completion / timeout-error pulses
//   turf_wr_o/turf_rd_o/turf_addr_o/turf_bank_o/turf_dat_o : downstream request
//   turf_dat_i / turf_ack_i : downstream read data and completion
//   timeout_count_o    : saturating count of timeouts
module turf_bus_arbiter
    import turf_bus_pkg::*;
#(
    parameter int TIMEOUT    = 256,
    parameter int GAP_CYCLES = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             m_wr_i,
    input  logic [1:0]             m_rd_i,
    input  logic [11:0]            m_addr_i,
    input  logic [3:0]             m_bank_i,
    input  logic [63:0]            m_dat_i,
    output logic [31:0]            m_dat_o,
    output logic [1:0]             m_ack_o,
    output logic [1:0]             m_err_o,
    output logic                   turf_wr_o,
    output logic                   turf_rd_o,
    output logic [TURF_ADDR_W-1:0] turf_addr_o,
    output logic [TURF_BANK_W-1:0] turf_bank_o,
    output logic [TURF_DATA_W-1:0] turf_dat_o,
    input  logic [TURF_DATA_W-1:0] turf_dat_i,
    input  logic                   turf_ack_i,
    output logic [CNT_WIDTH-1:0]   timeout_count_o
);

    // One timer serves both the ISSUE timeout and the GAP length.
    localparam int TMR_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic                     sel_q, sel_d;
    logic                     turf_wr_q, turf_wr_d;
    logic                     turf_rd_q, turf_rd_d;
    logic [TURF_ADDR_W-1:0]   addr_q, addr_d;
    logic [TURF_BANK_W-1:0]   bank_q, bank_d;
    logic [TURF_DATA_W-1:0]   wdat_q, wdat_d;
    logic [TURF_DATA_W-1:0]   rdat_q, rdat_d;
    logic [1:0]               ack_q, ack_d;
    logic [1:0]               err_q, err_d;
    logic [CNT_WIDTH-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       gnt_sel;

    assign req     = m_wr_i | m_rd_i;
    assign gnt_sel = gnt[1];

    turf_rr_arb2 u_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req),
        .grant_en_i (state_q == IDLE),
        .gnt_o      (gnt)
    );

    // Next-state and output logic. Ack/err are single-cycle pulses, so they
    // default to zero; everything else holds unless a transition changes it.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sel_d     = sel_q;
        turf_wr_d = turf_wr_q;
        turf_rd_d = turf_rd_q;
        addr_d    = addr_q;
        bank_d    = bank_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        ack_d     = 2'b00;
        err_d     = 2'b00;
        tmo_cnt_d = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // Write wins when a master raises both strobes.
                    state_d   = ISSUE;
                    timer_d   = '0;
                    sel_d     = gnt_sel;
                    turf_wr_d = m_wr_i[gnt_sel];
                    turf_rd_d = ~m_wr_i[gnt_sel];
                    addr_d    = gnt_sel ? m_addr_i[11:6]  : m_addr_i[5:0];
                    bank_d    = gnt_sel ? m_bank_i[3:2]   : m_bank_i[1:0];
                    wdat_d    = gnt_sel ? m_dat_i[63:32]  : m_dat_i[31:0];
                end
            end

            ISSUE: begin
                // A real ack takes priority over a timeout in the same cycle.
                if (turf_ack_i) begin
                    state_d      = GAP;
                    timer_d      = '0;
                    turf_wr_d    = 1'b0;
                    turf_rd_d    = 1'b0;
                    ack_d[sel_q] = 1'b1;
                    rdat_d       = turf_wr_q ? '0 : turf_dat_i;
                end else if (timer_q == TMO_LAST) begin
                    state_d      = GAP;
                    timer_d      = '0;
                    turf_wr_d    = 1'b0;
                    turf_rd_d    = 1'b0;
                    ack_d[sel_q] = 1'b1;
                    err_d[sel_q] = 1'b1;
                    rdat_d       = TURF_ERR_DATA;
                    if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            GAP: begin
                // Late acks arriving here are deliberately ignored.
                if (timer_q == GAP_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            sel_q     <= 1'b0;
            turf_wr_q <= 1'b0;
            turf_rd_q <= 1'b0;
            addr_q    <= '0;
            bank_q    <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            ack_q     <= 2'b00;
            err_q     <= 2'b00;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sel_q     <= sel_d;
            turf_wr_q <= turf_wr_d;
            turf_rd_q <= turf_rd_d;
            addr_q    <= addr_d;
            bank_q    <= bank_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign turf_wr_o       = turf_wr_q;
    assign turf_rd_o       = turf_rd_q;
    assign turf_addr_o     = addr_q;
    assign turf_bank_o     = bank_q;
    assign turf_dat_o      = wdat_q;
    assign m_dat_o         = rdat_q;
    assign m_ack_o         = ack_q;
    assign m_err_o         = err_q;
    assign timeout_count_o = tmo_cnt_q;

endmodule

// File: tb/tb_turf_bus_arbiter.sv
// Self-checking bench for turf_bus_arbiter. Transactions are described at the
// request/response level; the expected grant, timing and returned data come
// from a small transaction model (round-robin pointer, timeout rule, gap
// length) kept in this file.
module tb_turf_bus_arbiter;

    localparam int TIMEOUT    = 256;
    localparam int GAP_CYCLES = 3;
    localparam int CNT_WIDTH  = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  m_wr_i = '0;
    logic [1:0]  m_rd_i = '0;
    logic [11:0] m_addr_i = '0;
    logic [3:0]  m_bank_i = '0;
    logic [63:0] m_dat_i = '0;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o;
    logic [1:0]  m_err_o;
    logic        turf_wr_o;
    logic        turf_rd_o;
    logic [5:0]  turf_addr_o;
    logic [1:0]  turf_bank_o;
    logic [31:0] turf_dat_o;
    logic [31:0] turf_dat_i = '0;
    logic        turf_ack_i = 1'b0;
    logic [CNT_WIDTH-1:0] timeout_count_o;

    int          checks = 0;
    int          errors = 0;
    int          lastGrant = 1;
    int          expTo = 0;
    logic [31:0] expDat = '0;

    turf_bus_arbiter #(
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .m_wr_i          (m_wr_i),
        .m_rd_i          (m_rd_i),
        .m_addr_i        (m_addr_i),
        .m_bank_i        (m_bank_i),
        .m_dat_i         (m_dat_i),
        .m_dat_o         (m_dat_o),
        .m_ack_o         (m_ack_o),
        .m_err_o         (m_err_o),
        .turf_wr_o       (turf_wr_o),
        .turf_rd_o       (turf_rd_o),
        .turf_addr_o     (turf_addr_o),
        .turf_bank_o     (turf_bank_o),
        .turf_dat_o      (turf_dat_o),
        .turf_dat_i      (turf_dat_i),
        .turf_ack_i      (turf_ack_i),
        .timeout_count_o (timeout_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge, where outputs are stable
    // and new inputs can be driven for the following edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] wr, input logic [1:0] rd,
                                 input logic [11:0] addr, input logic [3:0] bank,
                                 input logic [63:0] dat);
        m_wr_i   = wr;
        m_rd_i   = rd;
        m_addr_i = addr;
        m_bank_i = bank;
        m_dat_i  = dat;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_wr"},  turf_wr_o, 0);
        checkOutput({tag, "_rd"},  turf_rd_o, 0);
        checkOutput({tag, "_ack"}, m_ack_o, 0);
        checkOutput({tag, "_err"}, m_err_o, 0);
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        applyStimulus(2'b00, 2'b00, '0, '0, '0);
        turf_ack_i = 1'b0;
        tick();
        checkIdleOutputs("rst");
        checkOutput("rst_mdat", m_dat_o, 0);
        checkOutput("rst_addr", turf_addr_o, 0);
        checkOutput("rst_wdat", turf_dat_o, 0);
        checkOutput("rst_tmo",  timeout_count_o, 0);
        rst_i     = 1'b0;
        lastGrant = 1;
        expTo     = 0;
        expDat    = '0;
    endtask

    // One full transaction from an IDLE arbiter: grant, hold, ack or timeout,
    // then the gap. lat < 0 means the downstream never acks.
    task automatic runTxn(input logic [1:0] wr, input logic [1:0] rd,
                          input logic [11:0] addr, input logic [3:0] bank,
                          input logic [63:0] dat, input int lat,
                          input logic [31:0] rdData, input bit ackInGap,
                          input bit scramble);
        logic [1:0]  req;
        int          g;
        bit          isWr;
        bit          timedOut;
        int          nHold;
        logic [5:0]  eAddr;
        logic [1:0]  eBank;
        logic [31:0] eWdat;
        req = wr | rd;
        if (req == 2'b11) g = (lastGrant == 1) ? 0 : 1;
        else              g = req[1] ? 1 : 0;
        lastGrant = g;
        isWr  = wr[g];
        eAddr = (g == 1) ? addr[11:6] : addr[5:0];
        eBank = (g == 1) ? bank[3:2]  : bank[1:0];
        eWdat = (g == 1) ? dat[63:32] : dat[31:0];

        applyStimulus(wr, rd, addr, bank, dat);
        tick();
        checkOutput("grant_wr",   turf_wr_o, isWr);
        checkOutput("grant_rd",   turf_rd_o, !isWr);
        checkOutput("grant_addr", turf_addr_o, eAddr);
        checkOutput("grant_bank", turf_bank_o, eBank);
        checkOutput("grant_wdat", turf_dat_o, eWdat);
        checkOutput("grant_ack",  m_ack_o, 0);

        if (scramble) begin
            m_addr_i = 12'($urandom);
            m_bank_i = 4'($urandom);
            m_dat_i  = {$urandom, $urandom};
            m_wr_i[g] = 1'b0;
            m_rd_i[g] = 1'b0;
        end

        timedOut = (lat < 0) || (lat >= TIMEOUT);
        nHold    = timedOut ? TIMEOUT - 1 : lat;
        for (int k = 1; k <= nHold; k++) begin
            tick();
            if (k <= 8 || k == nHold) begin
                checkOutput("hold_wr",   turf_wr_o, isWr);
                checkOutput("hold_rd",   turf_rd_o, !isWr);
                checkOutput("hold_addr", turf_addr_o, eAddr);
                checkOutput("hold_ack",  m_ack_o, 0);
            end
        end
        if (!timedOut) begin
            turf_ack_i = 1'b1;
            turf_dat_i = rdData;
        end
        tick();
        turf_ack_i = 1'b0;
        turf_dat_i = $urandom;

        if (timedOut) begin
            if (expTo < (1 << CNT_WIDTH) - 1) expTo++;
            expDat = 32'hFFFFFFFF;
        end else begin
            expDat = isWr ? 32'h0 : rdData;
        end
        checkOutput("done_ack",  m_ack_o, 2'b01 << g);
        checkOutput("done_err",  m_err_o, timedOut ? (2'b01 << g) : 2'b00);
        checkOutput("done_mdat", m_dat_o, expDat);
        checkOutput("done_wr",   turf_wr_o, 0);
        checkOutput("done_rd",   turf_rd_o, 0);
        checkOutput("done_tmo",  timeout_count_o, expTo);

        for (int k = 0; k < GAP_CYCLES; k++) begin
            if (ackInGap) turf_ack_i = 1'b1;
            tick();
            checkIdleOutputs("gap");
            checkOutput("gap_mdat", m_dat_o, expDat);
        end
        turf_ack_i = 1'b0;
    endtask

    initial begin
        logic [1:0] rWr;
        logic [1:0] rRd;

        // Reset state, then a tie straight out of reset and held ties.
        doReset();
        tick();
        checkIdleOutputs("idle");
        runTxn(2'b11, 2'b00, 12'h2C5, 4'hB, 64'hAAAA0001_BBBB0000, 1,
               32'h0, 1'b0, 1'b0);
        runTxn(2'b11, 2'b00, 12'h2C5, 4'hB, 64'hAAAA0001_BBBB0000, 0,
               32'h0, 1'b0, 1'b0);
        runTxn(2'b00, 2'b11, 12'h3F1, 4'h6, 64'h0, 3,
               32'h11112222, 1'b0, 1'b0);
        runTxn(2'b00, 2'b11, 12'h3F1, 4'h6, 64'h0, 2,
               32'h33334444, 1'b0, 1'b0);

        // Master 0 write, ack two cycles after the strobe appears.
        runTxn(2'b01, 2'b00, 12'h008, 4'b0010, 64'h0_01234567, 2,
               32'h5A5A5A5A, 1'b0, 1'b0);
        // Master 1 read returning CAFEF00D.
        runTxn(2'b00, 2'b10, 12'h000, 4'b0000, 64'h0, 1,
               32'hCAFEF00D, 1'b0, 1'b0);
        // Both strobes from one master: the write wins.
        runTxn(2'b10, 2'b10, 12'h540, 4'hC, 64'h87654321_0, 0,
               32'hDEADBEEF, 1'b0, 1'b0);
        // Ack in the very last ISSUE cycle is a normal completion.
        runTxn(2'b00, 2'b01, 12'h015, 4'h1, 64'h0, TIMEOUT - 1,
               32'h600DCAFE, 1'b0, 1'b0);
        // Downstream never acks; a late ack during the gap is ignored.
        runTxn(2'b00, 2'b01, 12'h022, 4'h2, 64'h0, -1,
               32'h0, 1'b1, 1'b0);

        // Randomized transactions with inputs disturbed mid-ISSUE.
        for (int n = 0; n < 40; n++) begin
            rWr = 2'($urandom_range(0, 3));
            rRd = 2'($urandom_range(0, 3));
            if ((rWr | rRd) == 2'b00) rRd = 2'b01;
            runTxn(rWr, rRd, 12'($urandom), 4'($urandom), {$urandom, $urandom},
                   int'($urandom_range(0, 6)), $urandom,
                   1'($urandom), 1'($urandom));
        end

        // Reset one cycle into ISSUE abandons the transaction.
        applyStimulus(2'b00, 2'b01, 12'h033, 4'h3, 64'h0);
        tick();
        checkOutput("pre_rst_rd", turf_rd_o, 1);
        tick();
        doReset();
        tick();
        checkIdleOutputs("post_rst");
        runTxn(2'b11, 2'b00, 12'h7C1, 4'h9, 64'h0BAD0BAD_12121212, 1,
               32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
